// File: rtl/muldiv_issue.sv
// muldiv_issue: issue/interlock controller between the execute stage and a
// multi-cycle multiply/divide engine that owns the HI/LO registers.
//
// State | Meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a new HI/LO-class op (op_ready = 1)
// RUN   | engine busy, md_Start held high, watchdog counting
// DRAIN | one cycle with md_Start low so the engine counter clears
// READ  | MFHI/MFLO in flight, md_Cout captured into res_data on exit
//
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   op_valid, op_code           instruction from execute
//                               (0 MULT, 1 MULTU, 2 DIV, 3 DIVU,
//                                4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO)
//   rs_val, rt_val              source operands
//   op_ready, stall             handshake / pipeline freeze
//   res_valid, res_data         MFHI/MFLO result (one-cycle pulse, held data)
//   div0                        pulse on accepting a divide by zero
//   err                         sticky watchdog timeout flag
//   md_a, md_b                  registered engine operands
//   md_Start, md_MorD, md_sign,
//   md_MulSelHL, md_MulWrite    registered engine controls
//   md_Cout, md_ready           engine result and completion

module muldiv_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        op_ready,
    output logic        stall,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic        div0,
    output logic        err,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        md_Start,
    output logic        md_MorD,
    output logic        md_sign,
    output logic        md_MulSelHL,
    output logic        md_MulWrite,
    input  logic [31:0] md_Cout,
    input  logic        md_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        READ  = 2'd3
    } state_t;

    // Timeout fires on the edge that ends the 48th RUN cycle.
    localparam logic [5:0] WD_LAST = 6'd47;

    state_t      state, state_nxt;
    logic [5:0]  wd_cnt, wd_cnt_nxt;

    logic [31:0] md_a_nxt, md_b_nxt, res_data_nxt;
    logic        start_nxt, mord_nxt, sign_nxt, selhl_nxt, mulwrite_nxt;
    logic        res_valid_nxt, div0_nxt, err_nxt;

    assign op_ready = (state == IDLE);
    assign stall    = op_valid & ~op_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            wd_cnt      <= '0;
            md_a        <= '0;
            md_b        <= '0;
            md_Start    <= 1'b0;
            md_MorD     <= 1'b0;
            md_sign     <= 1'b0;
            md_MulSelHL <= 1'b0;
            md_MulWrite <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            div0        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            wd_cnt      <= wd_cnt_nxt;
            md_a        <= md_a_nxt;
            md_b        <= md_b_nxt;
            md_Start    <= start_nxt;
            md_MorD     <= mord_nxt;
            md_sign     <= sign_nxt;
            md_MulSelHL <= selhl_nxt;
            md_MulWrite <= mulwrite_nxt;
            res_valid   <= res_valid_nxt;
            res_data    <= res_data_nxt;
            div0        <= div0_nxt;
            err         <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        wd_cnt_nxt    = wd_cnt;
        md_a_nxt      = md_a;
        md_b_nxt      = md_b;
        start_nxt     = md_Start;
        mord_nxt      = md_MorD;
        sign_nxt      = md_sign;
        selhl_nxt     = md_MulSelHL;
        mulwrite_nxt  = 1'b0;
        res_valid_nxt = 1'b0;
        res_data_nxt  = res_data;
        div0_nxt      = 1'b0;
        err_nxt       = err;

        case (state)
            IDLE: begin
                if (op_valid) begin
                    case (op_code)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            md_a_nxt   = rs_val;
                            md_b_nxt   = rt_val;
                            mord_nxt   = op_code[1];
                            sign_nxt   = ~op_code[0];
                            start_nxt  = 1'b1;
                            wd_cnt_nxt = '0;
                            div0_nxt   = op_code[1] & (rt_val == 32'd0);
                            state_nxt  = RUN;
                        end
                        3'd4, 3'd5: begin
                            // MFHI selects HI (1), MFLO selects LO (0)
                            selhl_nxt = ~op_code[0];
                            state_nxt = READ;
                        end
                        default: begin
                            // MTHI/MTLO: single write strobe, stay in IDLE
                            md_a_nxt     = rs_val;
                            selhl_nxt    = ~op_code[0];
                            mulwrite_nxt = 1'b1;
                        end
                    endcase
                end
            end
            RUN: begin
                if (md_Start && md_ready) begin
                    start_nxt = 1'b0;
                    state_nxt = DRAIN;
                end else if (wd_cnt == WD_LAST) begin
                    start_nxt = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = DRAIN;
                end else begin
                    wd_cnt_nxt = wd_cnt + 6'd1;
                end
            end
            DRAIN: begin
                state_nxt = IDLE;
            end
            READ: begin
                res_data_nxt  = md_Cout;
                res_valid_nxt = 1'b1;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_muldiv_issue.sv
// Testbench for muldiv_issue: a behavioural HI/LO engine stub drives md_Cout /
// md_ready, and a reference model computes HI/LO from the issued
// instruction stream with plain arithmetic.

module tb_muldiv_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] rs_val, rt_val;
    logic        op_ready, stall, res_valid, div0, err;
    logic [31:0] res_data, md_a, md_b, md_Cout;
    logic        md_Start, md_MorD, md_sign, md_MulSelHL, md_MulWrite, md_ready;

    int checks = 0;
    int failures = 0;

    // engine stub state
    logic [31:0] eng_hi = '0, eng_lo = '0;
    int          eng_cnt = 0;
    int          eng_lat = 2;
    logic        eng_hang = 1'b0;

    // reference model
    logic [31:0] ref_hi = '0, ref_lo = '0;
    logic        hi_def = 1'b0, lo_def = 1'b0;

    always #5 clk = ~clk;

    muldiv_issue dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .rs_val(rs_val), .rt_val(rt_val), .op_ready(op_ready), .stall(stall),
        .res_valid(res_valid), .res_data(res_data), .div0(div0), .err(err),
        .md_a(md_a), .md_b(md_b), .md_Start(md_Start), .md_MorD(md_MorD),
        .md_sign(md_sign), .md_MulSelHL(md_MulSelHL), .md_MulWrite(md_MulWrite),
        .md_Cout(md_Cout), .md_ready(md_ready)
    );

    assign md_Cout  = md_MulSelHL ? eng_hi : eng_lo;
    assign md_ready = md_Start && !eng_hang && (eng_cnt >= eng_lat);

    function automatic logic [63:0] engine_calc(input logic [31:0] a, input logic [31:0] b,
                                                input logic mord, input logic sgn);
        longint    sa64, sb64;
        int        sa, sb;
        logic [63:0] p;
        if (!mord) begin
            if (sgn) begin
                sa64 = $signed(a);
                sb64 = $signed(b);
                p = 64'(sa64 * sb64);
            end else begin
                p = {32'd0, a} * {32'd0, b};
            end
        end else if (b == 32'd0) begin
            p = '0;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, a};
            else begin
                sa = a; sb = b;
                p = {32'(sa % sb), 32'(sa / sb)};
            end
        end else begin
            p = {a % b, a / b};
        end
        return p;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            eng_cnt <= 0;
        end else begin
            eng_cnt <= md_Start ? eng_cnt + 1 : 0;
            if (md_Start && md_ready)
                {eng_hi, eng_lo} <= engine_calc(md_a, md_b, md_MorD, md_sign);
            if (md_MulWrite) begin
                if (md_MulSelHL) eng_hi <= md_a;
                else             eng_lo <= md_a;
            end
        end
    end

    // Present an op at a negedge, wait (bounded) for op_ready, update the
    // reference model, let the accept edge pass and return at the next negedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         output int waited, output int bad_stall);
        longint    sa, sb, sp;
        int        qa, qb;
        logic [63:0] up;
        op_valid = 1'b1; op_code = op; rs_val = rs; rt_val = rt;
        waited = 0; bad_stall = 0;
        #1;
        while (op_ready !== 1'b1 && waited < 200) begin
            if (stall !== 1'b1) bad_stall++;
            @(negedge clk); #1;
            waited++;
        end
        if (waited >= 200) begin
            checks++; failures++;
            $display("FAIL issue_timeout op=%0d waited=%0d required<200", op, waited);
        end
        case (op)
            3'd0: begin
                sa = $signed(rs); sb = $signed(rt); sp = sa * sb;
                ref_hi = sp[63:32]; ref_lo = sp[31:0]; hi_def = 1; lo_def = 1;
            end
            3'd1: begin
                up = {32'd0, rs} * {32'd0, rt};
                ref_hi = up[63:32]; ref_lo = up[31:0]; hi_def = 1; lo_def = 1;
            end
            3'd2: begin
                if (rt == 0) begin hi_def = 0; lo_def = 0; end
                else begin
                    qa = rs; qb = rt;
                    ref_lo = qa / qb; ref_hi = qa % qb; hi_def = 1; lo_def = 1;
                end
            end
            3'd3: begin
                if (rt == 0) begin hi_def = 0; lo_def = 0; end
                else begin ref_lo = rs / rt; ref_hi = rs % rt; hi_def = 1; lo_def = 1; end
            end
            3'd6: begin ref_hi = rs; hi_def = 1; end
            3'd7: begin ref_lo = rs; lo_def = 1; end
            default: ;
        endcase
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        #1;
    endtask

    // Issue MFHI/MFLO and observe four cycles after the accept edge
    // (k = number of edges since accept at which res_valid is seen).
    task automatic read_hilo(input logic [2:0] op, output logic [31:0] data, output int first,
                             output int pulses, output int waited, output int bad_stall);
        issue(op, 32'd0, 32'd0, waited, bad_stall);
        first = 0; pulses = 0; data = '0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) begin @(negedge clk); #1; end
            if (res_valid === 1'b1) begin
                pulses++;
                if (first == 0) begin first = k; data = res_data; end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; op_valid = 1'b1; op_code = 3'd0;
        rs_val = 32'hDEAD_BEEF; rt_val = 32'h1234_5678;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (md_Start !== 1'b0) begin failures++; $display("FAIL reset_md_start got=%0b exp=0", md_Start); end
        checks++; if (md_a !== 32'd0 || md_b !== 32'd0) begin failures++; $display("FAIL reset_operands got=%h/%h exp=0/0", md_a, md_b); end
        checks++; if (res_data !== 32'd0 || res_valid !== 1'b0) begin failures++; $display("FAIL reset_res got=%h/%b exp=0/0", res_data, res_valid); end
        checks++; if ({div0, err, md_MulWrite, md_MulSelHL, md_MorD, md_sign} !== 6'd0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=000000", {div0, err, md_MulWrite, md_MulSelHL, md_MorD, md_sign}); end
        checks++; if (op_ready !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL reset_handshake got=%b/%b exp=1/0", op_ready, stall); end
        op_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk); #1;
        checks++; if (op_ready !== 1'b1 || md_Start !== 1'b0) begin failures++; $display("FAIL reset_idle got=%b/%b exp=1/0", op_ready, md_Start); end
    endtask

    task automatic test_mult();
        int w, bs, first, pulses;
        logic [31:0] d;
        eng_lat = 2;
        issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0007, w, bs);
        checks++; if (md_a !== 32'hFFFF_FFFD || md_b !== 32'h7) begin failures++; $display("FAIL mult_operands got=%h/%h exp=fffffffd/7", md_a, md_b); end
        checks++; if ({md_Start, md_MorD, md_sign, op_ready} !== 4'b1010) begin
            failures++; $display("FAIL mult_ctrl got=%b exp=1010", {md_Start, md_MorD, md_sign, op_ready}); end
        read_hilo(3'd4, d, first, pulses, w, bs);
        checks++; if (w != eng_lat + 2 || bs != 0) begin failures++; $display("FAIL mult_stall got wait=%0d bad=%0d exp wait=%0d bad=0", w, bs, eng_lat + 2); end
        checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_mfhi got=%h exp=ffffffff", d); end
        checks++; if (first != 2 || pulses != 1) begin failures++; $display("FAIL mult_res_valid got first=%0d n=%0d exp 2/1", first, pulses); end
        read_hilo(3'd5, d, first, pulses, w, bs);
        checks++; if (d !== 32'hFFFF_FFEB || w != 0) begin failures++; $display("FAIL mult_mflo got=%h wait=%0d exp=ffffffeb/0", d, w); end
    endtask

    task automatic test_divu();
        int w, bs, first, pulses, d0_seen;
        logic [31:0] d;
        eng_lat = 4;
        issue(3'd3, 32'd100, 32'd7, w, bs);
        d0_seen = (div0 === 1'b1) ? 1 : 0;
        checks++; if (md_MorD !== 1'b1 || md_sign !== 1'b0) begin failures++; $display("FAIL divu_ctrl got=%b%b exp=10", md_MorD, md_sign); end
        @(negedge clk); #1;
        if (div0 === 1'b1) d0_seen = 1;
        read_hilo(3'd5, d, first, pulses, w, bs);
        checks++; if (d !== 32'h0000_000E || pulses != 1) begin failures++; $display("FAIL divu_mflo got=%h n=%0d exp=0000000e/1", d, pulses); end
        read_hilo(3'd4, d, first, pulses, w, bs);
        checks++; if (d !== 32'h0000_0002) begin failures++; $display("FAIL divu_mfhi got=%h exp=00000002", d); end
        checks++; if (d0_seen != 0) begin failures++; $display("FAIL divu_div0 got=1 exp=0"); end
    endtask

    task automatic test_mthi();
        int w, bs, first, pulses;
        logic [31:0] d, v;
        issue(3'd6, 32'h1234_5678, 32'd0, w, bs);
        checks++; if ({md_MulWrite, md_MulSelHL, md_Start, op_ready} !== 4'b1101) begin
            failures++; $display("FAIL mthi_write got=%b exp=1101", {md_MulWrite, md_MulSelHL, md_Start, op_ready}); end
        @(negedge clk); #1;
        checks++; if (md_MulWrite !== 1'b0) begin failures++; $display("FAIL mthi_single_pulse got=%b exp=0", md_MulWrite); end
        read_hilo(3'd4, d, first, pulses, w, bs);
        checks++; if (d !== 32'h1234_5678 || first != 2 || pulses != 1) begin
            failures++; $display("FAIL mthi_mfhi got=%h first=%0d n=%0d exp=12345678/2/1", d, first, pulses); end
        v = $urandom;
        issue(3'd7, v, 32'd0, w, bs);
        checks++; if (md_MulWrite !== 1'b1 || md_MulSelHL !== 1'b0) begin failures++; $display("FAIL mtlo_write got=%b%b exp=10", md_MulWrite, md_MulSelHL); end
        read_hilo(3'd5, d, first, pulses, w, bs);
        checks++; if (d !== v) begin failures++; $display("FAIL mtlo_mflo got=%h exp=%h", d, v); end
    endtask

    task automatic test_interlock();
        int w, bs, first, pulses;
        logic [31:0] d, a, b;
        eng_lat = 3;
        a = $urandom; b = $urandom_range(1, 1000);
        issue(3'd2, a, b, w, bs);
        read_hilo(3'd5, d, first, pulses, w, bs);
        checks++; if (w != eng_lat + 2 || bs != 0) begin failures++; $display("FAIL interlock_hold got wait=%0d bad=%0d exp wait=%0d bad=0", w, bs, eng_lat + 2); end
        checks++; if (d !== ref_lo || first != 2) begin failures++; $display("FAIL interlock_quotient got=%h first=%0d exp=%h/2", d, first, ref_lo); end
    endtask

    task automatic test_watchdog();
        int w, bs, starts, guard;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL wd_err_before got=%b exp=0", err); end
        eng_hang = 1'b1;
        issue(3'd2, $urandom, 32'd0, w, bs);
        checks++; if (div0 !== 1'b1 || md_Start !== 1'b1) begin failures++; $display("FAIL wd_div0_pulse got=%b/%b exp=1/1", div0, md_Start); end
        starts = 1; guard = 0;
        @(negedge clk); #1;
        checks++; if (div0 !== 1'b0) begin failures++; $display("FAIL wd_div0_len got=%b exp=0", div0); end
        while (md_Start === 1'b1 && guard < 100) begin
            starts++;
            @(negedge clk); #1;
            guard++;
        end
        checks++; if (starts != 48) begin failures++; $display("FAIL wd_run_cycles got=%0d exp=48", starts); end
        checks++; if (err !== 1'b1 || op_ready !== 1'b0) begin failures++; $display("FAIL wd_drain got err=%b rdy=%b exp=1/0", err, op_ready); end
        @(negedge clk); #1;
        checks++; if (op_ready !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL wd_idle got rdy=%b err=%b exp=1/1", op_ready, err); end
        eng_hang = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int w, bs;
        eng_hang = 1'b1;
        issue(3'd0, $urandom, $urandom, w, bs);
        repeat (9) @(negedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk); #1;
        checks++; if ({md_Start, op_ready, err, res_valid} !== 4'b0100) begin
            failures++; $display("FAIL reset_run got=%b exp=0100", {md_Start, op_ready, err, res_valid}); end
        checks++; if (md_a !== 32'd0 || md_b !== 32'd0) begin failures++; $display("FAIL reset_run_ops got=%h/%h exp=0/0", md_a, md_b); end
        reset = 1'b1; eng_hang = 1'b0;
        hi_def = 1'b0; lo_def = 1'b0;
        @(negedge clk); #1;
        checks++; if (op_ready !== 1'b1 || md_Start !== 1'b0) begin failures++; $display("FAIL reset_run_after got=%b/%b exp=1/0", op_ready, md_Start); end
    endtask

    task automatic test_random();
        int w, bs, first, pulses, gap;
        logic [31:0] d, a, b, exp_d;
        logic [2:0] op;
        logic def;
        for (int n = 0; n < 80; n++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk); #1;
                checks++;
                if (res_valid !== 1'b0 || md_MulWrite !== 1'b0 || div0 !== 1'b0 || (md_Start & md_MulWrite) !== 1'b0) begin
                    failures++; $display("FAIL rnd_idle_pulse n=%0d got rv=%b mw=%b d0=%b exp 0/0/0", n, res_valid, md_MulWrite, div0);
                end
            end
            op = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            if (b == 32'd0) b = 32'd1;
            if (op == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            eng_lat = $urandom_range(0, 4);
            if (op == 3'd4 || op == 3'd5) begin
                exp_d = (op == 3'd4) ? ref_hi : ref_lo;
                def   = (op == 3'd4) ? hi_def : lo_def;
                read_hilo(op, d, first, pulses, w, bs);
                checks++;
                if ((def && d !== exp_d) || first != 2 || pulses != 1 || bs != 0) begin
                    failures++; $display("FAIL rnd_read n=%0d op=%0d got=%h first=%0d n=%0d exp=%h/2/1", n, op, d, first, pulses, exp_d);
                end
            end else begin
                issue(op, a, b, w, bs);
                checks++;
                if (op < 3'd4) begin
                    if (md_a !== a || md_b !== b || md_MorD !== op[1] || md_sign !== !op[0] ||
                        md_Start !== 1'b1 || div0 !== 1'b0 || md_MulWrite !== 1'b0 || bs != 0) begin
                        failures++; $display("FAIL rnd_muldiv n=%0d op=%0d got a=%h b=%h m=%b s=%b st=%b exp a=%h b=%h", n, op, md_a, md_b, md_MorD, md_sign, md_Start, a, b);
                    end
                end else begin
                    if (md_a !== a || md_MulWrite !== 1'b1 || md_MulSelHL !== (op == 3'd6) || md_Start !== 1'b0) begin
                        failures++; $display("FAIL rnd_mt n=%0d op=%0d got a=%h mw=%b hl=%b exp a=%h", n, op, md_a, md_MulWrite, md_MulSelHL, a);
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0; op_valid = 1'b0; op_code = 3'd0; rs_val = '0; rt_val = '0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_divu();
        test_mthi();
        test_interlock();
        test_watchdog();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_issue.md
MULDIV_ISSUE -- requirements
Module: muldiv_issue

Interface
REQ-001 The block SHALL have these ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-003 op_valid  in  1  execute stage presents a HI/LO-class instruction.
REQ-004 op_code  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
REQ-005 rs_val, rt_val  in  32 each  source operands (dividend/multiplicand = rs, divisor/multiplier = rt; MTxx data = rs).
REQ-006 op_ready  out  1  op accepted on the edge where op_valid and op_ready are both high.
REQ-007 stall  out  1  pipeline freeze; equals op_valid and not op_ready.
REQ-008 res_valid  out  1  one-cycle pulse, res_data holds an MFHI/MFLO result.
REQ-009 res_data  out  32  last MFHI/MFLO result, held until the next read completes.
REQ-010 div0  out  1  one-cycle pulse on accepting DIV/DIVU with rt_val==0.
REQ-011 err  out  1  sticky watchdog error, cleared only by reset.
REQ-012 md_a, md_b  out  32 each  registered operands to the multiply/divide engine.
REQ-013 md_Start, md_MorD, md_sign, md_MulSelHL, md_MulWrite  out  1 each  registered engine controls (MorD 1 = divide; sign 1 = signed).
REQ-014 md_Cout  in  32, md_ready  in  1  engine result and completion; md_ready is meaningful only while md_Start is high.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DRAIN, READ; op_ready SHALL be high only in IDLE.
REQ-016 IDLE + accepted MULT/MULTU/DIV/DIVU: latch md_a=rs_val, md_b=rt_val, md_MorD=op_code[1], md_sign=~op_code[0], set md_Start=1, enter RUN.
REQ-017 md_a, md_b, md_MorD, md_sign SHALL remain constant from accept until return to IDLE.
REQ-018 RUN: md_Start held 1; on an edge with md_Start and md_ready both high, clear md_Start and enter DRAIN.
REQ-019 DRAIN: one cycle with md_Start=0 so the engine counter clears, then IDLE.
REQ-020 IDLE + accepted MTHI/MTLO: md_a=rs_val, md_MulSelHL=op_code[0]==0 (HI), md_MulWrite=1 for exactly one cycle; remain IDLE; md_Start stays 0.
REQ-021 IDLE + accepted MFHI/MFLO: md_MulSelHL=(op_code==MFHI), enter READ; on the READ edge, res_data<=md_Cout, res_valid<=1, return to IDLE.
REQ-022 res_valid SHALL be high exactly one cycle, two edges after the accept edge.
REQ-023 MFxx/MTxx/new mul-div issued in RUN or DRAIN SHALL be held off (op_ready 0, stall 1) and accepted in the first IDLE cycle (HI/LO interlock).
REQ-024 div0 SHALL pulse one cycle after accept; the division still runs and HI/LO content is architecturally undefined.
REQ-025 Watchdog: a 6-bit counter cleared on entering RUN and incrementing each RUN cycle; reaching 48 without completion SHALL clear md_Start, set err, and enter DRAIN.
REQ-026 md_MulWrite and md_Start SHALL never be high in the same cycle.
REQ-027 With op_valid low, all state outputs SHALL hold; no spurious pulses.

Reset
REQ-028 With reset low at an edge: state=IDLE; md_Start, md_MulWrite, md_MulSelHL, md_MorD, md_sign, res_valid, div0, err = 0; md_a, md_b, res_data = 0; watchdog counter = 0.
REQ-029 Reset during RUN/DRAIN/READ SHALL abort the operation on that edge; op_ready = 1 the following cycle; the engine is reset by the top level in the same cycle.
REQ-030 Reset SHALL take precedence over every simultaneous accept or completion.

Verification
REQ-031 MULT rs=0xFFFFFFFD, rt=0x00000007, then MFHI, MFLO -> res_data 0xFFFFFFFF, then 0xFFFFFFEB; stall high throughout RUN/DRAIN.
REQ-032 DIVU rs=100, rt=7, then MFLO, MFHI -> 0x0000000E, then 0x00000002; div0 stays 0.
REQ-033 MTHI rs=0x12345678, then MFHI -> single md_MulWrite pulse with md_MulSelHL=1; res_data 0x12345678 with res_valid two edges after the MFHI accept.
REQ-034 MFLO presented the cycle after a DIV accept -> op_ready 0 until IDLE; accepted on the first IDLE cycle; returns the quotient.
REQ-035 DIV rt=0 with engine md_ready tied 0 -> div0 pulse; after 48 RUN cycles md_Start=0, err=1, then IDLE.
REQ-036 reset asserted at RUN cycle 10 of a MULT -> next cycle md_Start=0, op_ready=1, err=0, res_valid=0.
